// File: rtl/shift_register.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : shift_register
// Brief    : Universal shift register (hold/load/shift/rotate/arith/clear)
//            with a flop-driven parallel output. Opcode 111 clears only when
//            SHIFT_REG_CLEAR_EN is defined, otherwise it holds.
// Revision : 1.0 - initial release
// ============================================================================
module shift_register #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out
);

  localparam logic [2:0] c_OP_HOLD = 3'b000;
  localparam logic [2:0] c_OP_LOAD = 3'b001;
  localparam logic [2:0] c_OP_SRL  = 3'b010;
  localparam logic [2:0] c_OP_SLL  = 3'b011;
  localparam logic [2:0] c_OP_ROR  = 3'b100;
  localparam logic [2:0] c_OP_ROL  = 3'b101;
  localparam logic [2:0] c_OP_SRA  = 3'b110;
  localparam logic [2:0] c_OP_CLR  = 3'b111;

  logic [WIDTH-1:0] r_q_q;
  logic [WIDTH-1:0] w_q_d;

  always_comb begin
    w_q_d = r_q_q;
    case (sel)
      c_OP_HOLD: w_q_d = r_q_q;
      c_OP_LOAD: w_q_d = d_in;
      c_OP_SRL:  w_q_d = {d_in[WIDTH-1], r_q_q[WIDTH-1:1]};
      c_OP_SLL:  w_q_d = {r_q_q[WIDTH-2:0], d_in[0]};
      c_OP_ROR:  w_q_d = {r_q_q[0], r_q_q[WIDTH-1:1]};
      c_OP_ROL:  w_q_d = {r_q_q[WIDTH-2:0], r_q_q[WIDTH-1]};
      c_OP_SRA:  w_q_d = {r_q_q[WIDTH-1], r_q_q[WIDTH-1:1]};
`ifdef SHIFT_REG_CLEAR_EN
      c_OP_CLR:  w_q_d = '0;
`else
      // Without the clear feature, opcode 111 aliases hold.
      c_OP_CLR:  w_q_d = r_q_q;
`endif
      default:   w_q_d = r_q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q_q <= '0;
    end else begin
      r_q_q <= w_q_d;
    end
  end

  assign d_out = r_q_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_register.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_shift_register
// Brief    : Table-driven, scoreboarded bench for shift_register (WIDTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_register;

  localparam int WIDTH = 4;

  typedef struct {
    logic             rst;
    logic [2:0]       op;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] exp;
    string            name;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] exp;
    string            name;
  } sb_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [2:0]       sel;
  logic [WIDTH-1:0] d_in;
  logic [WIDTH-1:0] d_out;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  vec_t vecs[$];
  sb_t  sb[$];

  shift_register #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .sel   (sel),
    .d_in  (d_in),
    .d_out (d_out)
  );

  always #5 clk = ~clk;

  // Independent reference for the hand-written multi-cycle sequences.
  function automatic logic [3:0] ref_op(input logic [3:0] q, input logic [2:0] s,
                                        input logic [3:0] din);
    logic [3:0] r;
    r = q;
    case (s)
      3'd1: r = din;
      3'd2: r = {din[3], q[3], q[2], q[1]};
      3'd3: r = {q[2], q[1], q[0], din[0]};
      3'd4: r = {q[0], q[3], q[2], q[1]};
      3'd5: r = {q[2], q[1], q[0], q[3]};
      3'd6: r = {q[3], q[3], q[2], q[1]};
`ifdef SHIFT_REG_CLEAR_EN
      3'd7: r = 4'b0000;
`endif
      default: r = q;
    endcase
    return r;
  endfunction

  task automatic add(input logic r, input logic [2:0] s, input logic [3:0] din,
                     input logic [3:0] e, input string n);
    vec_t v;
    v.rst = r; v.op = s; v.din = din; v.exp = e; v.name = n;
    vecs.push_back(v);
  endtask

  task automatic apply(input logic r, input logic [2:0] s, input logic [3:0] din,
                       input logic [3:0] e, input string n);
    sb_t item;
    @(negedge clk);
    reset = r;
    sel   = s;
    d_in  = din;
    item.exp  = e;
    item.name = n;
    sb.push_back(item);
  endtask

  // Monitor: compare each scoreboard entry just after the edge that produces it.
  initial begin
    sb_t item;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        item = sb.pop_front();
        checks++;
        if (d_out === item.exp) begin
          passes++;
        end else begin
          fails++;
          $display("FAIL %s: d_out=%b expected=%b", item.name, d_out, item.exp);
        end
      end
    end
  end

  initial begin
    logic [3:0] q;
    int         wait_cycles;

    reset = 1'b0;
    sel   = 3'b000;
    d_in  = '0;

    add(1'b1, 3'b001, 4'b1111, 4'b0000, "reset_priority");
    add(1'b0, 3'b001, 4'b0101, 4'b0101, "load_after_reset");
    add(1'b0, 3'b000, 4'b1101, 4'b0101, "hold_1");
    add(1'b0, 3'b000, 4'b1101, 4'b0101, "hold_2");
    add(1'b0, 3'b000, 4'b1101, 4'b0101, "hold_3");
    add(1'b0, 3'b100, 4'b0000, 4'b1010, "ror_1");
    add(1'b0, 3'b100, 4'b0000, 4'b0101, "ror_2");
    add(1'b0, 3'b001, 4'b1100, 4'b1100, "load_1100");
    add(1'b0, 3'b101, 4'b0000, 4'b1001, "rol_1");
    add(1'b0, 3'b101, 4'b0000, 4'b0011, "rol_2");
    add(1'b0, 3'b001, 4'b1001, 4'b1001, "load_1001a");
    add(1'b0, 3'b110, 4'b1111, 4'b1100, "sra");
    add(1'b0, 3'b001, 4'b1001, 4'b1001, "load_1001b");
    add(1'b0, 3'b010, 4'b0110, 4'b0100, "srl_msb0");
    add(1'b0, 3'b001, 4'b0110, 4'b0110, "load_0110a");
    add(1'b0, 3'b011, 4'b1110, 4'b1100, "sll_lsb0");
    add(1'b0, 3'b001, 4'b0110, 4'b0110, "load_0110b");
    add(1'b0, 3'b011, 4'b0001, 4'b1101, "sll_lsb1");
    add(1'b0, 3'b001, 4'b1010, 4'b1010, "load_1010");
`ifdef SHIFT_REG_CLEAR_EN
    add(1'b0, 3'b111, 4'b1111, 4'b0000, "clear");
`else
    add(1'b0, 3'b111, 4'b1111, 4'b1010, "clear_disabled_hold");
`endif
    add(1'b0, 3'b001, 4'b1111, 4'b1111, "load_1111");
    add(1'b0, 3'b100, 4'b0000, 4'b1111, "ror_1111_1");
    add(1'b0, 3'b100, 4'b0000, 4'b1111, "ror_1111_2");
    add(1'b1, 3'b100, 4'b0000, 4'b0000, "reset_mid_op");
    add(1'b0, 3'b001, 4'b0010, 4'b0010, "load_after_mid_reset");

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].op, vecs[i].din, vecs[i].exp, vecs[i].name);
    end

    // WIDTH rotates return to start; mixed-bit pattern exposes misrouted bits.
    q = 4'b1011;
    apply(1'b0, 3'b001, q, q, "load_1011");
    for (int k = 0; k < WIDTH; k++) begin
      q = ref_op(q, 3'b101, 4'b0000);
      apply(1'b0, 3'b101, 4'b0000, q, "rol_seq");
    end
    for (int k = 0; k < WIDTH; k++) begin
      q = ref_op(q, 3'b100, 4'b0000);
      apply(1'b0, 3'b100, 4'b0000, q, "ror_seq");
    end
    // WIDTH logical shifts leave only serial-in bits.
    for (int k = 0; k < WIDTH; k++) begin
      q = ref_op(q, 3'b010, 4'b1000);
      apply(1'b0, 3'b010, 4'b1000, q, "srl_fill1");
    end
    for (int k = 0; k < WIDTH; k++) begin
      q = ref_op(q, 3'b011, 4'b1110);
      apply(1'b0, 3'b011, 4'b1110, q, "sll_fill0");
    end
    // Sign replication from a negative value saturates to all ones.
    q = 4'b1000;
    apply(1'b0, 3'b001, q, q, "load_1000");
    for (int k = 0; k < WIDTH; k++) begin
      q = ref_op(q, 3'b110, 4'b0000);
      apply(1'b0, 3'b110, 4'b0000, q, "sra_seq");
    end
    apply(1'b0, 3'b111, 4'b0000, ref_op(q, 3'b111, 4'b0000), "clear_after_sra");

    wait_cycles = 0;
    while (sb.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    if (sb.size() > 0) begin
      checks++;
      fails++;
      $display("FAIL scoreboard_drain: pending=%0d expected=0", sb.size());
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
